// File: rtl/uart_wb_arb.sv
// Arbiter/sequencer sharing the uart_wb slave port between a CPU Wishbone master and a byte stream.
// Define UART_WB_ARB_RR_EN for round-robin on simultaneous requests; fixed CPU priority otherwise.
module uart_wb_arb #(
    parameter int unsigned DW        = 16,
    parameter int unsigned STALL_MAX = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    c_addr,
    input  logic [DW-1:0] c_wdata,
    input  logic          c_we,
    input  logic          c_cyc,
    output logic [DW-1:0] c_rdata,
    output logic          c_ack,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [1:0]    u_addr,
    output logic [DW-1:0] u_wdata,
    output logic          u_we,
    output logic          u_cyc,
    input  logic [DW-1:0] u_rdata,
    input  logic          u_ack,
    output logic [1:0]    grant
);

    localparam int unsigned CW = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CPU   = 2'd1,
        S_STR   = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          force_q, force_d;
    logic          cpu_wins;
    logic          take_cpu;

`ifdef UART_WB_ARB_RR_EN
    // Last contested winner: 1 = stream, 0 = CPU.
    logic last_q, last_d;
    assign cpu_wins = last_q;
`else
    assign cpu_wins = 1'b1;
`endif

    assign take_cpu = c_cyc && (force_q || !s_valid || cpu_wins);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            byte_q  <= '0;
            force_q <= 1'b0;
`ifdef UART_WB_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            force_q <= force_d;
`ifdef UART_WB_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        force_d = force_q;
`ifdef UART_WB_ARB_RR_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (take_cpu) begin
                    state_d = S_CPU;
                    force_d = 1'b0;
`ifdef UART_WB_ARB_RR_EN
                    if (s_valid) last_d = 1'b0;
`endif
                end else if (s_valid) begin
                    state_d = S_STR;
                    byte_d  = s_data;
                    cnt_d   = '0;
                    force_d = 1'b0;
`ifdef UART_WB_ARB_RR_EN
                    if (c_cyc) last_d = 1'b1;
`endif
                end
            end
            S_CPU: begin
                if (u_ack) state_d = S_IDLE;
            end
            S_STR: begin
                // A stalled stream write yields only when the CPU is actually waiting.
                if (u_ack) begin
                    state_d = S_IDLE;
                end else if ((cnt_q == CW'(STALL_MAX)) && c_cyc) begin
                    state_d = S_ABORT;
                end else if (cnt_q != CW'(STALL_MAX)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ABORT: begin
                state_d = S_IDLE;
                force_d = 1'b1;
`ifdef UART_WB_ARB_RR_EN
                last_d  = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus steering decoded from the registered state; acks pass straight through.
    always_comb begin
        u_cyc   = 1'b0;
        u_addr  = 2'd0;
        u_we    = 1'b0;
        u_wdata = '0;
        grant   = 2'b00;
        c_ack   = 1'b0;
        c_rdata = '0;
        s_ready = 1'b0;
        unique case (state_q)
            S_CPU: begin
                u_cyc   = 1'b1;
                u_addr  = c_addr;
                u_we    = c_we;
                u_wdata = c_wdata;
                grant   = 2'b01;
                c_ack   = u_ack;
                c_rdata = u_rdata;
            end
            S_STR: begin
                u_cyc   = 1'b1;
                u_we    = 1'b1;
                u_wdata = {{(DW-8){1'b0}}, byte_q};
                grant   = 2'b10;
                s_ready = u_ack;
            end
            S_ABORT: s_ready = u_ack;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_wb_arb.sv
// Directed self-checking bench for uart_wb_arb with a registered-ack uart_wb stand-in.
module tb_uart_wb_arb;

    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    c_addr = 2'd0;
    logic [DW-1:0] c_wdata = '0;
    logic          c_we = 1'b0;
    logic          c_cyc = 1'b0;
    logic [DW-1:0] c_rdata;
    logic          c_ack;
    logic [7:0]    s_data = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [1:0]    u_addr;
    logic [DW-1:0] u_wdata;
    logic          u_we;
    logic          u_cyc;
    logic [DW-1:0] u_rdata;
    logic          u_ack;
    logic [1:0]    grant;

    logic ack_q;
    logic ack_en = 1'b1;
    logic ack_force = 1'b0;

    int n_eval = 0;
    int n_fail = 0;
    int sr_cnt = 0;
    int wr_cnt = 0;
    logic [DW-1:0] last_wr = '0;

    uart_wb_arb #(.DW(DW), .STALL_MAX(64)) dut (
        .clk(clk), .rst(rst),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_we(c_we), .c_cyc(c_cyc),
        .c_rdata(c_rdata), .c_ack(c_ack),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .u_addr(u_addr), .u_wdata(u_wdata), .u_we(u_we), .u_cyc(u_cyc),
        .u_rdata(u_rdata), .u_ack(u_ack), .grant(grant)
    );

    always #5 clk = ~clk;

    // Slave model: ack one cycle after u_cyc, never two in a row.
    always @(posedge clk or posedge rst) begin
        if (rst) ack_q <= 1'b0;
        else     ack_q <= ack_en && u_cyc && !ack_q;
    end
    assign u_ack   = ack_q | ack_force;
    assign u_rdata = 16'h8005;

    always @(posedge clk) begin
        if (s_ready) sr_cnt <= sr_cnt + 1;
        if (u_cyc && u_ack && u_we && (u_addr == 2'd0)) begin
            wr_cnt  <= wr_cnt + 1;
            last_wr <= u_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // kind 0: grant==g, 1: c_ack, 2: s_ready, other: grant!=g
    task automatic wait_until(input int kind, input logic [1:0] g, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            case (kind)
                0:       hit = (grant === g);
                1:       hit = (c_ack === 1'b1);
                2:       hit = (s_ready === 1'b1);
                default: hit = (grant !== g);
            endcase
            if (hit) break;
            @(negedge clk);
        end
        check(tag, {31'd0, hit}, 32'd1);
    endtask

    initial begin
        logic [7:0] bytes [3];
        logic [1:0] exp_g [4];
        int base_sr;
        int base_wr;
        int n;
        bit saw_str;

        bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
`ifdef UART_WB_ARB_RR_EN
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif

        // Reset values
        #2;
        check("rst_u_cyc", 32'(u_cyc), 32'd0);
        check("rst_u_we", 32'(u_we), 32'd0);
        check("rst_u_addr", 32'(u_addr), 32'd0);
        check("rst_u_wdata", 32'(u_wdata), 32'd0);
        check("rst_c_ack", 32'(c_ack), 32'd0);
        check("rst_c_rdata", 32'(c_rdata), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // CPU read of address 1
        c_addr = 2'd1; c_we = 1'b0; c_cyc = 1'b1;
        tick();
        check("cpu_c1_u_cyc", 32'(u_cyc), 32'd1);
        check("cpu_c1_u_addr", 32'(u_addr), 32'd1);
        check("cpu_c1_u_we", 32'(u_we), 32'd0);
        check("cpu_c1_grant", 32'(grant), 32'd1);
        check("cpu_c1_c_ack", 32'(c_ack), 32'd0);
        tick();
        check("cpu_c2_c_ack", 32'(c_ack), 32'd1);
        check("cpu_c2_c_rdata", 32'(c_rdata), 32'h8005);
        c_cyc = 1'b0;
        tick();
        check("cpu_c3_u_cyc", 32'(u_cyc), 32'd0);
        check("cpu_c3_c_rdata", 32'(c_rdata), 32'd0);
        check("cpu_c3_grant", 32'(grant), 32'd0);

        // Stream of three bytes, one every three cycles
        for (int i = 0; i < 3; i++) begin
            s_data = bytes[i]; s_valid = 1'b1;
            tick();
            check("str_u_cyc", 32'(u_cyc), 32'd1);
            check("str_u_addr", 32'(u_addr), 32'd0);
            check("str_u_we", 32'(u_we), 32'd1);
            check("str_u_wdata", 32'(u_wdata), {24'd0, bytes[i]});
            check("str_grant", 32'(grant), 32'd2);
            check("str_ready_early", 32'(s_ready), 32'd0);
            tick();
            check("str_ready", 32'(s_ready), 32'd1);
            if (i == 2) s_valid = 1'b0;
            tick();
            check("str_gap_u_cyc", 32'(u_cyc), 32'd0);
            check("str_gap_ready", 32'(s_ready), 32'd0);
        end

        // Contested requests held from reset
        rst = 1'b1;
        c_addr = 2'd0; c_we = 1'b0; c_cyc = 1'b1;
        s_data = 8'h77; s_valid = 1'b1;
        tick();
        base_sr = sr_cnt;
        rst = 1'b0;
        for (int g = 0; g < 4; g++) begin
            wait_until(3, 2'b00, "arb_wait_grant");
            check("arb_grant", 32'(grant), 32'(exp_g[g]));
            wait_until(0, 2'b00, "arb_wait_idle");
        end
        c_cyc = 1'b0; s_valid = 1'b0;
        tick(); tick(); tick();
`ifdef UART_WB_ARB_RR_EN
        check("arb_str_acks", 32'(sr_cnt - base_sr), 32'd2);
`else
        check("arb_str_acks", 32'(sr_cnt - base_sr), 32'd0);
`endif

        // Stalled stream byte abandoned for a waiting CPU, then retried
        ack_en = 1'b0;
        s_data = 8'h55; s_valid = 1'b1;
        base_sr = sr_cnt;
        tick();
        c_addr = 2'd0; c_we = 1'b1; c_wdata = 16'h1234; c_cyc = 1'b1;
        n = 0;
        for (int i = 0; i < 200 && grant == 2'b10; i++) begin
            n++;
            tick();
        end
        check("abort_stall_len", 32'((n >= 64) && (n <= 65)), 32'd1);
        check("abort_u_cyc", 32'(u_cyc), 32'd0);
        check("abort_no_ready", 32'(sr_cnt - base_sr), 32'd0);
        ack_en = 1'b1;
        tick();
        check("abort_idle_grant", 32'(grant), 32'd0);
        tick();
        check("abort_cpu_grant", 32'(grant), 32'd1);
        check("abort_cpu_wdata", 32'(u_wdata), 32'h1234);
        wait_until(1, 2'b00, "abort_wait_cack");
        c_cyc = 1'b0; c_we = 1'b0;
        wait_until(0, 2'b10, "abort_wait_retry");
        check("retry_wdata", 32'(u_wdata), 32'h0055);
        wait_until(2, 2'b00, "retry_wait_ready");
        s_valid = 1'b0;
        tick(); tick();
        check("retry_acks", 32'(sr_cnt - base_sr), 32'd1);
        check("retry_last_wr", 32'(last_wr), 32'h0055);

        // Ack arrives in the ABORT cycle
        ack_en = 1'b0;
        s_data = 8'h5A; s_valid = 1'b1;
        base_sr = sr_cnt;
        tick();
        c_addr = 2'd2; c_we = 1'b0; c_cyc = 1'b1;
        wait_until(4, 2'b10, "late_wait_abort");
        check("late_u_cyc", 32'(u_cyc), 32'd0);
        ack_force = 1'b1;
        #1;
        check("late_s_ready", 32'(s_ready), 32'd1);
        check("late_c_ack", 32'(c_ack), 32'd0);
        s_valid = 1'b0;
        tick();
        ack_force = 1'b0; ack_en = 1'b1;
        check("late_idle_grant", 32'(grant), 32'd0);
        tick();
        check("late_cpu_grant", 32'(grant), 32'd1);
        wait_until(1, 2'b00, "late_wait_cack");
        c_cyc = 1'b0;
        saw_str = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (grant == 2'b10) saw_str = 1'b1;
        end
        check("late_no_retry", 32'(saw_str), 32'd0);
        check("late_acks", 32'(sr_cnt - base_sr), 32'd1);

        // Reset in the middle of a stream write
        ack_en = 1'b0;
        s_data = 8'h66; s_valid = 1'b1;
        tick(); tick();
        ack_force = 1'b1;
        #1;
        check("mid_s_ready_pre", 32'(s_ready), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_u_cyc", 32'(u_cyc), 32'd0);
        check("mid_s_ready", 32'(s_ready), 32'd0);
        check("mid_c_ack", 32'(c_ack), 32'd0);
        check("mid_grant", 32'(grant), 32'd0);
        check("mid_u_wdata", 32'(u_wdata), 32'd0);
        ack_force = 1'b0;
        base_sr = sr_cnt;
        base_wr = wr_cnt;
        tick(); tick();
        rst = 1'b0; ack_en = 1'b1;
        wait_until(2, 2'b00, "mid_wait_ready");
        s_valid = 1'b0;
        repeat (5) tick();
        check("mid_acks", 32'(sr_cnt - base_sr), 32'd1);
        check("mid_writes", 32'(wr_cnt - base_wr), 32'd1);
        check("mid_last_wr", 32'(last_wr), 32'h0066);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
